// File: rtl/seq_divider64.sv
// Iterative radix-2 restoring divider: 2N-bit dividend / N-bit divisor.
// Produces one quotient bit per clock; divide-by-zero and overflow resolve in one cycle.
module seq_divider64 #(
  parameter int unsigned N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N:0]      prem_q, prem_d;
  logic [N-1:0]    low_q, low_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    quotient_q, quotient_d;
  logic [N-1:0]    remainder_q, remainder_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [N+1:0]    prem_sh;
  logic [N:0]      trial;
  logic            qbit;

  // Next-state and datapath for one restoring step per RUN cycle
  always_comb begin
    state_d     = state_q;
    prem_d      = prem_q;
    low_d       = low_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;

    prem_sh = {prem_q, low_q[N-1]};
    qbit    = (prem_sh >= {2'b00, dvs_q});
    trial   = prem_sh[N:0] - {1'b0, dvs_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          cnt_d = '0;
          dvs_d = divisor;
          if (divisor == '0) begin
            dbz_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend[N-1:0];
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else if (dividend[2*N-1:N] >= divisor) begin
            ovf_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend[N-1:0];
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            prem_d  = {1'b0, dividend[2*N-1:N]};
            low_d   = dividend[N-1:0];
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        prem_d = qbit ? trial : prem_sh[N:0];
        low_d  = {low_q[N-2:0], qbit};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          quotient_d  = low_d;
          remainder_d = prem_d[N-1:0];
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prem_q      <= '0;
      low_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prem_q      <= prem_d;
      low_q       <= low_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider64.sv
// Self-checking bench for seq_divider64 (N=32): directed vector table,
// handshake/reset corner sequences and a multiply/divide round trip.
module tb_seq_divider64;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  seq_divider64 #(.N(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for idle, pulse start for one edge, then count edges until done
  task automatic run_op(input logic [63:0] dvd, input logic [31:0] dvs, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~dvd;
    divisor  = ~dvs;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  vec_t vecs[12];
  int   lat;
  int   t1, t2, w;
  logic [31:0] ra, rb, rr;
  logic [63:0] rdvd;

  initial begin
    vecs[0]  = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33};
    vecs[1]  = '{64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33};
    vecs[2]  = '{64'h1234_5678_9ABC_DEF0, 32'd0, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0, 1};
    vecs[3]  = '{64'h5_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1};
    vecs[4]  = '{64'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1};
    vecs[5]  = '{64'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 33};
    vecs[6]  = '{64'h0000_0004_FFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd4, 1'b0, 1'b0, 33};
    vecs[7]  = '{64'd12345, 32'd1, 32'd12345, 32'd0, 1'b0, 1'b0, 33};
    vecs[8]  = '{64'h1_0000_0000, 32'd2, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 33};
    vecs[9]  = '{64'd0, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 33};
    vecs[10] = '{64'h7_0000_0003, 32'd7, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b1, 1};
    vecs[11] = '{64'd1000000007, 32'd1000, 32'd1000000, 32'd7, 1'b0, 1'b0, 33};

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_remainder", 64'(remainder), 64'd0);
    chk("reset_flags", 64'({div_by_zero, overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, lat);
      chk($sformatf("v%0d_done", i), 64'(done), 64'd1);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_quotient", i), 64'(quotient), 64'(vecs[i].q));
      chk($sformatf("v%0d_remainder", i), 64'(remainder), 64'(vecs[i].r));
      chk($sformatf("v%0d_div_by_zero", i), 64'(div_by_zero), 64'(vecs[i].dbz));
      chk($sformatf("v%0d_overflow", i), 64'(overflow), 64'(vecs[i].ovf));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // Results hold after done
    repeat (5) @(posedge clk);
    #1;
    chk("hold_quotient", 64'(quotient), 64'd1000000);
    chk("hold_remainder", 64'(remainder), 64'd7);
    chk("hold_busy", 64'(busy), 64'd0);

    // Start held high: accepted only once per N+2 cycles
    @(negedge clk);
    dividend = 64'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
    end
    start = 1'b0;
    chk("cont_first_done", 64'(t1), 64'd33);
    chk("cont_period", 64'(t2 - t1), 64'd34);
    chk("cont_quotient", 64'(quotient), 64'd3);
    w = 0;
    while (busy && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("cont_drain_idle", 64'(busy), 64'd0);

    // Asynchronous reset in RUN cycle 10
    @(negedge clk);
    dividend = 64'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("midrun_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_done", 64'(done), 64'd0);
    chk("midrun_rst_quotient", 64'(quotient), 64'd0);
    chk("midrun_rst_remainder", 64'(remainder), 64'd0);
    chk("midrun_rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(64'd9, 32'd3, lat);
    chk("post_rst_latency", 64'(lat), 64'd33);
    chk("post_rst_quotient", 64'(quotient), 64'd3);
    chk("post_rst_remainder", 64'(remainder), 64'd0);

    // Round trip: dividend = a*b + r with r < b
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = rb >> (i % 31);
      if (rb == 0) rb = 32'd1;
      rr = $urandom % rb;
      rdvd = 64'(ra) * 64'(rb) + 64'(rr);
      run_op(rdvd, rb, lat);
      chk($sformatf("rt%0d_quotient", i), 64'(quotient), 64'(ra));
      chk($sformatf("rt%0d_remainder", i), 64'(remainder), 64'(rr));
      if (i % 100 == 0) begin
        chk($sformatf("rt%0d_flags", i), 64'({div_by_zero, overflow}), 64'd0);
        chk($sformatf("rt%0d_latency", i), 64'(lat), 64'd33);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
